// File: rtl/mem_sweep_pkg.sv
// Shared types and constants for the memory sweep reader and its helpers.
package mem_sweep_pkg;

    // Sequencer states: one read is issued, awaited and presented per word.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } mem_sweep_state_t;

    // Largest supported memory read latency in cycles.
    localparam int RD_LAT_MAX = 4;

    // Ceiling log2 (minimum 1) used to size the latency counter.
    function automatic int lat_cnt_width(input int max_count);
        int w;
        w = 1;
        while ((1 << w) < max_count) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_sweep_lat_cnt.sv
// Read-latency counter: cleared while a read is issued, counts while waiting
// and flags the cycle in which returning read data must be captured.
module mem_sweep_lat_cnt
    import mem_sweep_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int                CNT_W = lat_cnt_width(RD_LAT_MAX);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(RD_LAT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter parks on its last value so it never wraps while waiting.
    assign expired_o = (cnt_q == LAST);

    // Next-count logic: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_sweep_reader.sv
// Memory sweep reader: on start, reads `length` consecutive words from a
// synchronous memory beginning at `base_addr` and streams each word out over
// a valid/ready handshake, then pulses done.
// Optional build macro MEM_SWEEP_CHECKSUM_EN adds a `checksum` output holding
// the modular sum of all words accepted during the current run.
module mem_sweep_reader
    import mem_sweep_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef MEM_SWEEP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    mem_sweep_state_t  state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic              rd_en_q,  rd_en_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              valid_q,  valid_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
`ifdef MEM_SWEEP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q,    sum_d;
`endif

    logic lat_clear_s;
    logic lat_enable_s;
    logic lat_expired_s;

    // The counter restarts on every issued read so each wait is measured
    // from the edge that samples mem_rd_en.
    assign lat_clear_s  = (state_q == ST_ISSUE);
    assign lat_enable_s = (state_q == ST_WAIT);

    mem_sweep_lat_cnt #(
        .RD_LAT (RD_LAT)
    ) u_lat_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (lat_clear_s),
        .enable_i  (lat_enable_s),
        .expired_o (lat_expired_s)
    );

    assign mem_addr  = addr_q;
    assign mem_rd_en = rd_en_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef MEM_SWEEP_CHECKSUM_EN
    assign checksum  = sum_q;
`endif

    // Next-state and next-output logic; the strobe and done outputs are
    // computed one cycle ahead so they come straight from registers.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        rd_en_d  = 1'b0;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef MEM_SWEEP_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = length;
                    busy_d   = 1'b1;
`ifdef MEM_SWEEP_CHECKSUM_EN
                    sum_d    = '0;
`endif
                    if (length == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        rd_en_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_expired_s) begin
                    data_d  = mem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    valid_d  = 1'b0;
                    remain_d = remain_q - (ADDR_W+1)'(1);
                    addr_d   = addr_q + ADDR_W'(1);
`ifdef MEM_SWEEP_CHECKSUM_EN
                    sum_d    = sum_q + data_q;
`endif
                    if (remain_q == (ADDR_W+1)'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        rd_en_d = 1'b1;
                    end
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            rd_en_q  <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MEM_SWEEP_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            rd_en_q  <= rd_en_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MEM_SWEEP_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_sweep_reader.sv
// Directed self-checking bench for mem_sweep_reader: one instance with
// RD_LAT=1 and one with RD_LAT=3, each fed by a latency-accurate memory model
// whose word at address a is a ^ 8'hA5 unless patched.
module tb_mem_sweep_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem [256];

    // Instance with RD_LAT = 1
    logic       start1, rd1, valid1, ready1, busy1, done1;
    logic [7:0] base1, addr1, rdata1, data1;
    logic [8:0] len1;
    // Instance with RD_LAT = 3
    logic       start3, rd3, valid3, ready3, busy3, done3;
    logic [7:0] base3, addr3, rdata3, data3;
    logic [8:0] len3;
`ifdef MEM_SWEEP_CHECKSUM_EN
    logic [7:0] csum1, csum3;
`endif

    mem_sweep_reader #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .base_addr(base1), .length(len1),
        .mem_addr(addr1), .mem_rd_en(rd1), .mem_rdata(rdata1), .out_data(data1),
        .out_valid(valid1), .out_ready(ready1), .busy(busy1), .done(done1)
`ifdef MEM_SWEEP_CHECKSUM_EN
        , .checksum(csum1)
`endif
    );

    mem_sweep_reader #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .base_addr(base3), .length(len3),
        .mem_addr(addr3), .mem_rd_en(rd3), .mem_rdata(rdata3), .out_data(data3),
        .out_valid(valid3), .out_ready(ready3), .busy(busy3), .done(done3)
`ifdef MEM_SWEEP_CHECKSUM_EN
        , .checksum(csum3)
`endif
    );

    // Cycle counter used to timestamp events.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: data is driven only for the one cycle in which it is
    // valid, so a capture at the wrong edge picks up 8'hEE.
    logic [7:0] p1, p2;
    always @(posedge clk) begin
        rdata1 <= rd1 ? mem[addr1] : 8'hEE;
        p1     <= rd3 ? mem[addr3] : 8'hEE;
        p2     <= p1;
        rdata3 <= p2;
    end

    // Monitor for the RD_LAT=1 instance; restarts on every accepted start.
    int         st1, fv1, dc1, n_str1, n_acc1;
    logic [7:0] str_a1 [300];
    logic [7:0] acc_d1 [300];
    int         acc_c1 [300];
    always @(negedge clk) begin
        if (start1 && !busy1) begin
            st1 <= cyc; fv1 <= -1; dc1 <= -1; n_str1 <= 0; n_acc1 <= 0;
        end else begin
            if (rd1) begin
                if (n_str1 < 300) str_a1[n_str1] <= addr1;
                n_str1 <= n_str1 + 1;
            end
            if (valid1 && fv1 < 0) fv1 <= cyc;
            if (valid1 && ready1) begin
                if (n_acc1 < 300) begin
                    acc_d1[n_acc1] <= data1;
                    acc_c1[n_acc1] <= cyc;
                end
                n_acc1 <= n_acc1 + 1;
            end
            if (done1) dc1 <= cyc;
        end
    end

    // Monitor for the RD_LAT=3 instance.
    int         st3, rc3, fv3, n_str3, n_acc3;
    logic [7:0] acc_d3 [4];
    always @(negedge clk) begin
        if (start3 && !busy3) begin
            st3 <= cyc; rc3 <= -1; fv3 <= -1; n_str3 <= 0; n_acc3 <= 0;
        end else begin
            if (rd3) begin
                if (rc3 < 0) rc3 <= cyc;
                n_str3 <= n_str3 + 1;
            end
            if (valid3 && fv3 < 0) fv3 <= cyc;
            if (valid3 && ready3) begin
                if (n_acc3 < 4) acc_d3[n_acc3] <= data3;
                n_acc3 <= n_acc3 + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the RD_LAT=1 instance, then scramble the run inputs.
    task automatic go1(input logic [7:0] b, input logic [8:0] l);
        base1  = b;
        len1   = l;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        base1  = 8'h77;
        len1   = 9'd5;
    endtask

    task automatic wait_done1(input int budget, input string tag);
        int n;
        n = 0;
        while (!done1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done1}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"},  {24'd0, addr1},  32'h0);
        check({tag, "_data"},  {24'd0, data1},  32'h0);
        check({tag, "_valid"}, {31'd0, valid1}, 32'd0);
        check({tag, "_rd_en"}, {31'd0, rd1},    32'd0);
        check({tag, "_busy"},  {31'd0, busy1},  32'd0);
        check({tag, "_done"},  {31'd0, done1},  32'd0);
`ifdef MEM_SWEEP_CHECKSUM_EN
        check({tag, "_csum"},  {24'd0, csum1},  32'h0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        logic [7:0] exp_b;
        for (int i = 0; i < 256; i++) begin
            exp_b  = i[7:0];
            mem[i] = exp_b ^ 8'hA5;
        end
        reset  = 1'b1;
        start1 = 1'b0; base1 = 8'h00; len1 = 9'd0; ready1 = 1'b1;
        start3 = 1'b0; base3 = 8'h00; len3 = 9'd0; ready3 = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic run: base 10, length 4, consumer always ready.
        go1(8'h10, 9'd4);
        wait_done1(40, "basic");
        check("basic_busy_in_done", {31'd0, busy1}, 32'd1);
        tick();
        check("basic_done_width", {31'd0, done1}, 32'd0);
        check("basic_busy_fall",  {31'd0, busy1}, 32'd0);
        check("basic_n_acc", n_acc1, 32'd4);
        check("basic_n_str", n_str1, 32'd4);
        check("basic_w0", {24'd0, acc_d1[0]}, 32'hB5);
        check("basic_w1", {24'd0, acc_d1[1]}, 32'hB4);
        check("basic_w2", {24'd0, acc_d1[2]}, 32'hB7);
        check("basic_w3", {24'd0, acc_d1[3]}, 32'hB6);
        check("basic_first_valid", fv1 - st1, 32'd3);
        for (int i = 0; i < 3; i++) check("basic_word_period", acc_c1[i+1] - acc_c1[i], 32'd3);
        check("basic_done_after_accept", dc1 - acc_c1[3], 32'd1);

        // Backpressure: hold word 2 for five cycles.
        go1(8'h10, 9'd4);
        n = 0;
        while (!(valid1 && addr1 == 8'h11) && n < 20) begin
            tick();
            n++;
        end
        check("bp_word2_seen", {31'd0, valid1}, 32'd1);
        ready1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, valid1}, 32'd1);
            check("bp_data",  {24'd0, data1},  32'hB4);
            check("bp_addr",  {24'd0, addr1},  32'h11);
            check("bp_rd_en", {31'd0, rd1},    32'd0);
            tick();
        end
        ready1 = 1'b1;
        wait_done1(40, "bp");
        tick();
        check("bp_n_str", n_str1, 32'd4);
        check("bp_n_acc", n_acc1, 32'd4);
        check("bp_w1", {24'd0, acc_d1[1]}, 32'hB4);
        check("bp_w3", {24'd0, acc_d1[3]}, 32'hB6);

        // Address wrap.
        go1(8'hFE, 9'd3);
        wait_done1(40, "wrap");
        tick();
        check("wrap_n_str", n_str1, 32'd3);
        check("wrap_a0", {24'd0, str_a1[0]}, 32'hFE);
        check("wrap_a1", {24'd0, str_a1[1]}, 32'hFF);
        check("wrap_a2", {24'd0, str_a1[2]}, 32'h00);
        check("wrap_w0", {24'd0, acc_d1[0]}, 32'h5B);
        check("wrap_w1", {24'd0, acc_d1[1]}, 32'h5A);
        check("wrap_w2", {24'd0, acc_d1[2]}, 32'hA5);

        // Zero length, plus a start during the done cycle that must be ignored.
        go1(8'h00, 9'd0);
        check("len0_done", {31'd0, done1}, 32'd1);
        check("len0_rd_en", {31'd0, rd1}, 32'd0);
        base1 = 8'h30; len1 = 9'd2; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("start_in_done_ignored", {31'd0, busy1}, 32'd0);
        tick();
        tick();
        check("start_in_done_still_idle", {31'd0, busy1}, 32'd0);
        check("len0_n_str", n_str1, 32'd0);
        check("len0_done_delay", dc1 - st1, 32'd1);

        // Full address space.
        go1(8'h00, 9'd256);
        wait_done1(900, "full");
        tick();
        check("full_n_str", n_str1, 32'd256);
        check("full_n_acc", n_acc1, 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            exp_b = i[7:0];
            if (str_a1[i] !== exp_b || acc_d1[i] !== (exp_b ^ 8'hA5)) bad++;
        end
        check("full_bad_words", bad, 32'd0);

        // Latency 3 on the second instance.
        base3 = 8'h00; len3 = 9'd2; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 40) begin
            tick();
            n++;
        end
        check("lat3_done_seen", {31'd0, done3}, 32'd1);
        tick();
        check("lat3_first_valid", fv3 - st3, 32'd5);
        check("lat3_rd_to_valid", fv3 - rc3, 32'd4);
        check("lat3_n_str", n_str3, 32'd2);
        check("lat3_n_acc", n_acc3, 32'd2);
        check("lat3_w0", {24'd0, acc_d3[0]}, 32'hA5);
        check("lat3_w1", {24'd0, acc_d3[1]}, 32'hA4);

        // Asynchronous reset while waiting for read data.
        go1(8'h10, 9'd4);
        tick();
        check("mid_busy_before_reset", {31'd0, busy1}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        go1(8'h20, 9'd2);
        base1 = 8'h50; len1 = 9'd3; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done1(40, "post_reset");
        tick();
        check("post_reset_n_str", n_str1, 32'd2);
        check("post_reset_a0", {24'd0, str_a1[0]}, 32'h20);
        check("post_reset_w0", {24'd0, acc_d1[0]}, 32'h85);
        check("post_reset_w1", {24'd0, acc_d1[1]}, 32'h84);

`ifdef MEM_SWEEP_CHECKSUM_EN
        // Checksum: 01 + 02 + FF wraps to 02.
        mem[8'h40] = 8'h01;
        mem[8'h41] = 8'h02;
        mem[8'h42] = 8'hFF;
        go1(8'h40, 9'd3);
        wait_done1(40, "csum");
        check("csum_at_done", {24'd0, csum1}, 32'h02);
        tick();
        tick();
        check("csum_held", {24'd0, csum1}, 32'h02);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_sweep_reader.md
Name: mem_sweep_reader

Overview:
- Parametrised successor to the team's fixed 8-bit, 256-word memory read sequencer.
- On a start pulse, reads a programmable run of consecutive words from a synchronous on-chip ROM/RAM. The run is defined by a base address and a length.
- Memory read latency is a parameter.
- Each word is presented on a valid/ready output stream, so the consumer can apply backpressure. A one-cycle done pulse marks the end of the run.
- Sits between the M9K-style memory and display/network-time consumers. Replaces the free-running sweep-and-restart scheme.

Parameters:
- ADDR_W, 8, memory address width; address space is 2^ADDR_W words.
- DATA_W, 8, memory data width.
- RD_LAT, 1, cycles from the clock edge sampling mem_rd_en to mem_rdata being valid. Legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; ignored unless busy=0.
- base_addr  in  ADDR_W  first address of the run; sampled on the accepted start.
- length  in  ADDR_W+1  number of words, 0..2^ADDR_W; sampled on the accepted start.
- mem_addr  out  ADDR_W  address to memory.
- mem_rd_en  out  1  read strobe, high exactly one cycle per word.
- mem_rdata  in  DATA_W  memory read data.
- out_data  out  DATA_W  captured word.
- out_valid  out  1  out_data holds a word not yet accepted.
- out_ready  in  1  consumer accepts when out_valid && out_ready at an edge.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - state=IDLE.
  - mem_addr, out_data, word counter and latency counter all 0.
  - mem_rd_en, out_valid, busy, done all 0.
  - Any in-flight read is discarded.
- States: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE:
  - On start: latch base_addr into mem_addr and length into the remaining-word counter.
  - If length==0, go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - mem_rd_en=1 for this cycle only; mem_addr is held stable.
  - Next state WAIT; latency counter cleared.
- WAIT:
  - Latency counter increments each cycle.
  - When the counter reaches RD_LAT-1, capture mem_rdata into out_data at that edge, set out_valid, and go to PRESENT.
  - mem_addr is held for the whole wait.
- PRESENT:
  - Hold out_data and out_valid until out_ready is sampled high.
  - On acceptance: clear out_valid, decrement the remaining-word counter, and increment mem_addr modulo 2^ADDR_W.
  - If the counter was 1, go to DONE. Otherwise go to ISSUE.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy is low from the IDLE cycle on.
- Timing:
  - First out_valid rises RD_LAT+2 cycles after the start edge.
  - With out_ready tied high, sustained throughput is one word per RD_LAT+2 cycles.
  - Only one read is outstanding at any time.
- busy=1 in ISSUE, WAIT, PRESENT and DONE.
- start while busy is ignored; base_addr and length changes mid-run have no effect.
- Address wrap: base_addr=2^ADDR_W-1 with length≥2 continues at address 0.
- length=2^ADDR_W reads every word exactly once.
- out_data is held after acceptance; it is not cleared.
- out_ready has no effect outside PRESENT.
- start arriving in the same cycle done is high is ignored. A new start is accepted from the following IDLE cycle.

Optional Feature:
- Macro: MEM_SWEEP_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (DATA_W bits).
  - checksum is a modular sum of every accepted word in the run.
  - It is cleared on each accepted start and is stable and valid while done=1 and afterwards, until the next start.
  - It resets to 0.
- When undefined: the port and its accumulator are absent; all other behaviour is identical.

Decomposition:
- Package mem_sweep_pkg holds:
  - the state enum type mem_sweep_state_t (5 states);
  - the constant RD_LAT_MAX=4;
  - a function returning clog2 for the latency counter width.
- Sub-module mem_sweep_lat_cnt: parametrised latency counter.
  - Inputs: clear, enable.
  - Output: expired, high on the count RD_LAT-1.
  - Instantiated once. It is reused by the planned write-back sequencer.

Test Plan:
- Basic run (RD_LAT=1): base=8'h10, length=4, out_ready=1, memory word = address XOR 8'hA5.
  - out_data sequence is B5, B4, B7, B6.
  - First out_valid 3 cycles after start; one word every 3 cycles.
  - done pulse one cycle after the last accept; busy falls with it.
- Backpressure: same run with out_ready low for 5 cycles on word 2.
  - out_data stable and out_valid high throughout.
  - No extra mem_rd_en; mem_addr stays 8'h11.
- Wrap and extremes:
  - base=8'hFE, length=3: addresses FE, FF, 00.
  - length=0: done one cycle after start, no mem_rd_en.
  - length=256: exactly 256 strobes.
- Latency sweep: RD_LAT=3, base=0, length=2. Capture happens 3 cycles after the mem_rd_en edge; first out_valid 5 cycles after start.
- Reset mid-run: assert reset asynchronously (between edges) while in WAIT.
  - All outputs 0 immediately.
  - A later start with base=8'h20 reads 8'h20 first.
  - A start pulsed while busy is ignored.
- Checksum, with MEM_SWEEP_CHECKSUM_EN: words 01, 02, FF give checksum 8'h02 at done.
